// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON types and constants
package ascon_pack;

    localparam int LANE_W   = 64;
    localparam int NB_LANES = 5;
    localparam int TAG_W    = 128;

    // Lane 0 sits in the low 64 bits, so state[0] is lane x0.
    typedef logic [NB_LANES-1:0][LANE_W-1:0] type_state;

    typedef enum logic {
        TAG_IDLE = 1'b0,
        TAG_HELD = 1'b1
    } type_tag_fsm;

endpackage

// File: rtl/ascon_block_cnt.sv
// rtl/ascon_block_cnt.sv - saturating ciphertext block counter with synchronous clear
module ascon_block_cnt #(
    parameter int NB_BLOCK_MAX = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(NB_BLOCK_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ascon_state_reg.sv
// rtl/ascon_state_reg.sv - ASCON state register closing the round loop, with cipher and tag capture
module ascon_state_reg
    import ascon_pack::*;
#(
    parameter int NB_BLOCK_MAX = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  type_state        init_state_i,
    input  type_state        state_i,
    input  logic             data_sel_i,
    input  logic             en_reg_state_i,
    input  logic             en_cipher_i,
    input  logic             en_tag_i,
    input  logic             tag_ack_i,
    input  logic             clr_cnt_i,
    output type_state        state_o,
    output logic [63:0]      cipher_o,
    output logic             cipher_valid_o,
    output logic [CNT_W-1:0] cipher_cnt_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             tag_valid_o
);

    type_state          state_d,        state_q;
    logic [63:0]        cipher_d,       cipher_q;
    logic               cipher_valid_d, cipher_valid_q;
    logic [TAG_W-1:0]   tag_d,          tag_q;
    type_tag_fsm        tag_fsm_d,      tag_fsm_q;

    always_comb begin
        state_d = state_q;
        if (en_reg_state_i) begin
            state_d = data_sel_i ? init_state_i : state_i;
        end
    end

    always_comb begin
        cipher_d       = en_cipher_i ? state_i[0] : cipher_q;
        cipher_valid_d = en_cipher_i;
    end

    // A fresh capture wins over a simultaneous acknowledge.
    always_comb begin
        tag_d     = tag_q;
        tag_fsm_d = tag_fsm_q;
        if (en_tag_i) begin
            tag_d     = {state_i[3], state_i[4]};
            tag_fsm_d = TAG_HELD;
        end else if (tag_fsm_q == TAG_HELD && tag_ack_i) begin
            tag_fsm_d = TAG_IDLE;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q        <= '0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            tag_q          <= '0;
            tag_fsm_q      <= TAG_IDLE;
        end else begin
            state_q        <= state_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
            tag_q          <= tag_d;
            tag_fsm_q      <= tag_fsm_d;
        end
    end

    ascon_block_cnt #(
        .NB_BLOCK_MAX (NB_BLOCK_MAX),
        .CNT_W        (CNT_W)
    ) u_block_cnt (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .inc_i    (en_cipher_i),
        .clr_i    (clr_cnt_i),
        .cnt_o    (cipher_cnt_o)
    );

    assign state_o        = state_q;
    assign cipher_o       = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign tag_o          = tag_q;
    assign tag_valid_o    = (tag_fsm_q == TAG_HELD);

endmodule

// File: tb/tb_ascon_state_reg.sv
// tb/tb_ascon_state_reg.sv - self-checking bench for ascon_state_reg
module tb_ascon_state_reg;
    import ascon_pack::*;

    logic          clock_i = 1'b0;
    logic          resetb_i;
    type_state     init_state_i, state_i, state_o;
    logic          data_sel_i, en_reg_state_i, en_cipher_i, en_tag_i, tag_ack_i, clr_cnt_i;
    logic [63:0]   cipher_o;
    logic          cipher_valid_o;
    logic [2:0]    cipher_cnt_o;
    logic [127:0]  tag_o;
    logic          tag_valid_o;

    ascon_state_reg #(.NB_BLOCK_MAX(4), .CNT_W(3)) dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .init_state_i   (init_state_i),
        .state_i        (state_i),
        .data_sel_i     (data_sel_i),
        .en_reg_state_i (en_reg_state_i),
        .en_cipher_i    (en_cipher_i),
        .en_tag_i       (en_tag_i),
        .tag_ack_i      (tag_ack_i),
        .clr_cnt_i      (clr_cnt_i),
        .state_o        (state_o),
        .cipher_o       (cipher_o),
        .cipher_valid_o (cipher_valid_o),
        .cipher_cnt_o   (cipher_cnt_o),
        .tag_o          (tag_o),
        .tag_valid_o    (tag_valid_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        en_c;
        logic        clr;
        logic [63:0] l0;
        logic [63:0] e_cipher;
        logic        e_cv;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct packed {
        logic [63:0] cipher;
        logic        cv;
        logic [2:0]  cnt;
    } sb_t;

    vec_t      vecs[14];
    sb_t       sb_q[$];
    sb_t       exp_e;
    int        total  = 0;
    int        passed = 0;
    type_state s_ref, s_alt, init_ref;
    logic [127:0] t0, t1;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_ctrl();
        data_sel_i = 0; en_reg_state_i = 0; en_cipher_i = 0;
        en_tag_i = 0; tag_ack_i = 0; clr_cnt_i = 0;
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_state"},  state_o,        '0);
        chk({tagname, "_cipher"}, cipher_o,       '0);
        chk({tagname, "_cvalid"}, cipher_valid_o, '0);
        chk({tagname, "_cnt"},    cipher_cnt_o,   '0);
        chk({tagname, "_tag"},    tag_o,          '0);
        chk({tagname, "_tvalid"}, tag_valid_o,    '0);
    endtask

    initial begin
        s_ref[0] = 64'h1b1354db77e0dbb4;
        s_ref[1] = 64'h6f140401cfa0873c;
        s_ref[2] = 64'hd7e8abaf45f2885a;
        s_ref[3] = 64'hc0c5777fa661625e;
        s_ref[4] = 64'hfc4374d28210928c;
        s_alt    = ~s_ref;
        init_ref[0] = 64'h80400c0600000000;
        init_ref[1] = 64'h0001020304050607;
        init_ref[2] = 64'h08090a0b0c0d0e0f;
        init_ref[3] = 64'h0011223344556677;
        init_ref[4] = 64'h8899aabbccddeeff;
        t0 = 128'hc0c5777fa661625efc4374d28210928c;
        t1 = ~t0;

        vecs[0]  = '{1'b1, 1'b0, 64'h1, 64'h1, 1'b1, 3'd1};
        vecs[1]  = '{1'b1, 1'b0, 64'h2, 64'h2, 1'b1, 3'd2};
        vecs[2]  = '{1'b1, 1'b0, 64'h3, 64'h3, 1'b1, 3'd3};
        vecs[3]  = '{1'b1, 1'b0, 64'h4, 64'h4, 1'b1, 3'd4};
        vecs[4]  = '{1'b1, 1'b0, 64'h5, 64'h5, 1'b1, 3'd4};
        vecs[5]  = '{1'b1, 1'b0, 64'h6, 64'h6, 1'b1, 3'd4};
        vecs[6]  = '{1'b0, 1'b0, 64'h7, 64'h6, 1'b0, 3'd4};
        vecs[7]  = '{1'b1, 1'b1, 64'h8, 64'h8, 1'b1, 3'd0};
        vecs[8]  = '{1'b1, 1'b0, 64'h9, 64'h9, 1'b1, 3'd1};
        vecs[9]  = '{1'b0, 1'b1, 64'ha, 64'h9, 1'b0, 3'd0};
        vecs[10] = '{1'b1, 1'b0, 64'hb, 64'hb, 1'b1, 3'd1};
        vecs[11] = '{1'b1, 1'b0, 64'hc, 64'hc, 1'b1, 3'd2};
        vecs[12] = '{1'b1, 1'b0, 64'hd, 64'hd, 1'b1, 3'd3};
        vecs[13] = '{1'b0, 1'b0, 64'he, 64'hd, 1'b0, 3'd3};

        idle_ctrl();
        init_state_i = init_ref;
        state_i      = '0;
        resetb_i     = 1'b0;
        #20;
        chk_all_zero("reset");
        resetb_i = 1'b1;
        step();

        data_sel_i = 1; en_reg_state_i = 1;
        step();
        idle_ctrl();
        chk("init_load_lane0", state_o[0], 64'h80400c0600000000);
        chk("init_load_full",  state_o,    init_ref);

        state_i = s_ref; en_reg_state_i = 1;
        step();
        chk("loopback", state_o, s_ref);
        idle_ctrl();
        data_sel_i = 1;
        state_i = s_alt;
        step();
        step();
        chk("hold", state_o, s_ref);
        idle_ctrl();

        state_i = s_ref; en_tag_i = 1;
        step();
        idle_ctrl();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("tag_held_valid_%0d", i), tag_valid_o, 1'b1);
            chk($sformatf("tag_held_value_%0d", i), tag_o, t0);
            step();
        end
        tag_ack_i = 1;
        step();
        chk("tag_ack_valid", tag_valid_o, 1'b0);
        chk("tag_ack_value", tag_o, t0);
        step();
        tag_ack_i = 0;
        chk("tag_ack_idle_valid", tag_valid_o, 1'b0);
        state_i = s_alt; en_tag_i = 1;
        step();
        chk("tag_reload_valid", tag_valid_o, 1'b1);
        chk("tag_reload_value", tag_o, t1);
        state_i = s_ref; en_tag_i = 1; tag_ack_i = 1;
        step();
        idle_ctrl();
        chk("tag_cap_ack_valid", tag_valid_o, 1'b1);
        chk("tag_cap_ack_value", tag_o, t0);

        for (int i = 0; i < 14; i++) begin
            state_i     = s_ref;
            state_i[0]  = vecs[i].l0;
            en_cipher_i = vecs[i].en_c;
            clr_cnt_i   = vecs[i].clr;
            sb_q.push_back('{vecs[i].e_cipher, vecs[i].e_cv, vecs[i].e_cnt});
            step();
            exp_e = sb_q.pop_front();
            chk($sformatf("cipher_%0d", i), cipher_o,       exp_e.cipher);
            chk($sformatf("cvalid_%0d", i), cipher_valid_o, exp_e.cv);
            chk($sformatf("cnt_%0d", i),    cipher_cnt_o,   exp_e.cnt);
        end
        idle_ctrl();

        state_i = s_ref; en_tag_i = 1;
        step();
        idle_ctrl();
        chk("pre_areset_tvalid", tag_valid_o, 1'b1);
        chk("pre_areset_cnt", cipher_cnt_o, 3'd3);
        #3;
        resetb_i = 1'b0;
        #2;
        chk_all_zero("areset");
        #2;
        resetb_i = 1'b1;
        step();
        chk_all_zero("post_areset");

        state_i = s_ref; en_reg_state_i = 1; en_cipher_i = 1; en_tag_i = 1;
        step();
        idle_ctrl();
        chk("indep_state",  state_o,        s_ref);
        chk("indep_cipher", cipher_o,       s_ref[0]);
        chk("indep_cvalid", cipher_valid_o, 1'b1);
        chk("indep_cnt",    cipher_cnt_o,   3'd1);
        chk("indep_tag",    tag_o,          t0);
        chk("indep_tvalid", tag_valid_o,    1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ascon_state_reg.md
Name: ascon_state_reg

Overview:
- Sequential stage directly downstream of xor_end and closing the permutation loop.
- Registers the five-lane ASCON state, either from the external initial value (IV||K||N) or from the xor_end output.
- Captures ciphertext blocks from lane 0 and the 128-bit tag from lanes 3/4, with valid/ack handshakes towards the top-level FSM and output interface.
- Its state_o feeds xor_begin at the head of the round datapath.

Parameters:
- NB_BLOCK_MAX, 4: number of ciphertext blocks per message; the block counter saturates here.
- CNT_W, 3: width of the block counter; must satisfy 2**CNT_W > NB_BLOCK_MAX.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- init_state_i  in  type_state  initial state IV||K||N.
- state_i  in  type_state  state from xor_end state_o.
- data_sel_i  in  1  1 selects init_state_i, 0 selects state_i.
- en_reg_state_i  in  1  load the state register.
- en_cipher_i  in  1  capture state_i[0] as a ciphertext block.
- en_tag_i  in  1  capture {state_i[3],state_i[4]} as the tag.
- tag_ack_i  in  1  consumer acknowledges the tag.
- clr_cnt_i  in  1  synchronous clear of the block counter.
- state_o  out  type_state  registered state, to xor_begin.
- cipher_o  out  64  last captured ciphertext block.
- cipher_valid_o  out  1  one-cycle pulse after each capture.
- cipher_cnt_o  out  CNT_W  number of blocks captured.
- tag_o  out  128  tag, state_i[3] in the MSBs, state_i[4] in the LSBs.
- tag_valid_o  out  1  sticky tag-available flag.

Behaviour:
- Reset (resetb_i=0, asynchronous, any time including mid-message): state_o lanes all 0, cipher_o=0, tag_o=0, cipher_valid_o=0, tag_valid_o=0, cipher_cnt_o=0.
- State register:
  - On a rising edge with en_reg_state_i=1, state_o <= data_sel_i ? init_state_i : state_i.
  - With en_reg_state_i=0, hold; data_sel_i is ignored.
  - Latency is one cycle. There is no combinational path from inputs to state_o.
- Cipher capture:
  - On an edge with en_cipher_i=1: cipher_o <= state_i[0], cipher_valid_o <= 1 for exactly the next cycle, and cipher_cnt_o increments.
  - The counter saturates at NB_BLOCK_MAX. A capture at saturation still updates cipher_o and pulses valid, but the count holds.
  - Back-to-back en_cipher_i gives a continuous valid high with a new cipher_o each cycle.
  - clr_cnt_i=1 forces the count to 0 and has priority over a simultaneous increment. The capture of cipher_o and the valid pulse still happen.
- Tag handshake, two-state FSM:
  - TAG_IDLE: tag_valid_o=0. On en_tag_i, load tag_o and go to TAG_HELD.
  - TAG_HELD: tag_valid_o=1 and tag_o is stable. tag_ack_i returns to TAG_IDLE; tag_o keeps its value.
  - en_tag_i together with tag_ack_i in TAG_HELD: the new tag is loaded and the FSM stays in TAG_HELD (capture wins).
  - tag_ack_i in TAG_IDLE is ignored.
- Independence: en_cipher_i, en_tag_i and en_reg_state_i may be asserted in the same cycle. Each acts on the same state_i sample independently.
- Width rules: all lanes are 64 bits; no arithmetic on data. The counter is unsigned CNT_W bits.

Decomposition:
- type_state (array of 5 x 64-bit lanes) lives in ascon_pack, which already exists.
- New entries for ascon_pack:
  - typedef type_tag_fsm with values TAG_IDLE and TAG_HELD.
  - constant TAG_W = 128.
- One natural sub-module: ascon_block_cnt, the saturating counter with clear, giving the NB_BLOCK_MAX and CNT_W behaviour.
- The state register and the capture logic stay in the top module.

Test Plan:
- Reset and init load: assert resetb_i=0 for 20 ns -> all outputs 0. Then, with init_state_i[0]=64'h80400c0600000000, data_sel_i=1 and en_reg_state_i=1 for one edge -> state_o[0]=64'h80400c0600000000 on the next cycle.
- Loopback and hold:
  - state_i={1b1354db77e0dbb4, 6f140401cfa0873c, d7e8abaf45f2885a, c0c5777fa661625e, fc4374d28210928c}, data_sel_i=0, en_reg_state_i=1 -> state_o equals state_i after 1 cycle.
  - Then drop en_reg_state_i and change state_i -> state_o unchanged.
- Tag handshake:
  - Same state_i with en_tag_i=1 for one cycle -> tag_o=128'hc0c5777fa661625efc4374d28210928c and tag_valid_o=1, held 5 cycles.
  - tag_ack_i=1 -> tag_valid_o=0 next cycle, tag_o unchanged.
  - en_tag_i together with tag_ack_i while held -> tag_valid_o stays 1 and tag_o takes the new value.
- Cipher counter saturation:
  - 6 consecutive en_cipher_i pulses with state_i[0]=64'h1,2,...,6 -> cipher_o=64'h6, cipher_valid_o high 6 cycles, cipher_cnt_o=4 (saturated).
  - clr_cnt_i together with en_cipher_i -> cipher_cnt_o=0 and the valid pulse still occurs.
- Asynchronous reset mid-operation: drop resetb_i between clock edges while tag_valid_o=1 and cipher_cnt_o=3 -> all outputs 0 immediately, without waiting for an edge.
